// File: rtl/aes_dec_pkg.sv
// Shared AES decryption constants, FSM state type and GF(2^8) helpers.
package aes_dec_pkg;

    localparam int unsigned AES_STATE_W  = 128;
    localparam int unsigned AES_COL_W    = 32;
    localparam int unsigned AES_NUM_COLS = 4;
    localparam logic [7:0]  GF_POLY      = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } inv_mc_state_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_col_unit.sv
// Combinational InvMixColumns on one 32-bit column, row 0 in the MSB byte.
module inv_mix_col_unit
    import aes_dec_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_i,
    output logic [AES_COL_W-1:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Row r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
    assign col_o = {
        gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
        gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3) ^ gf_mul9(a0),
        gf_mule(a2) ^ gf_mulb(a3) ^ gf_muld(a0) ^ gf_mul9(a1),
        gf_mule(a3) ^ gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2)
    };

endmodule

// File: rtl/inv_mix_col_seq.sv
// Column-serial InvMixColumns sequencer with valid/ready ports and final-round bypass.
// Define INV_MIX_COL_DUAL_EN to process two columns per BUSY cycle.
module inv_mix_col_seq
    import aes_dec_pkg::*;
#(
    parameter int unsigned NUM_COLS = AES_NUM_COLS,
    parameter int unsigned COL_W    = AES_COL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_COLS*COL_W-1:0] in_state,
    input  logic                      in_bypass,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_COLS*COL_W-1:0] out_state,
    output logic                      busy
);

    localparam int unsigned STATE_W = NUM_COLS * COL_W;
    localparam int unsigned CNT_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
`ifdef INV_MIX_COL_DUAL_EN
    localparam int unsigned UNITS   = 2;
`else
    localparam int unsigned UNITS   = 1;
`endif
    localparam int unsigned LAST_COL = NUM_COLS - UNITS;

    inv_mc_state_t        state_q, state_d;
    logic [CNT_W-1:0]     col_q, col_d;
    logic [STATE_W-1:0]   work_q, work_d;
    logic [STATE_W-1:0]   out_state_q, out_state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [COL_W-1:0]     col_a, res_a;
`ifdef INV_MIX_COL_DUAL_EN
    logic [COL_W-1:0]     col_b, res_b;
`endif

    // Select the work column(s) addressed by the counter
    always_comb begin
        col_a = '0;
`ifdef INV_MIX_COL_DUAL_EN
        col_b = '0;
`endif
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (CNT_W'(c) == col_q) col_a = work_q[STATE_W-1-COL_W*c -: COL_W];
`ifdef INV_MIX_COL_DUAL_EN
            if (CNT_W'(c) == col_q + CNT_W'(1)) col_b = work_q[STATE_W-1-COL_W*c -: COL_W];
`endif
        end
    end

    inv_mix_col_unit u_unit_a (
        .col_i (col_a),
        .col_o (res_a)
    );

`ifdef INV_MIX_COL_DUAL_EN
    inv_mix_col_unit u_unit_b (
        .col_i (col_b),
        .col_o (res_b)
    );
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        work_d      = work_q;
        out_state_d = out_state_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d = in_state;
                    if (in_bypass) begin
                        out_state_d = in_state;
                        state_d     = DONE;
                    end else begin
                        col_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    if (CNT_W'(c) == col_q) out_state_d[STATE_W-1-COL_W*c -: COL_W] = res_a;
`ifdef INV_MIX_COL_DUAL_EN
                    if (CNT_W'(c) == col_q + CNT_W'(1)) out_state_d[STATE_W-1-COL_W*c -: COL_W] = res_b;
`endif
                end
                if (col_q == CNT_W'(LAST_COL)) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + CNT_W'(UNITS);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            out_state_q <= out_state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Directed and randomized self-checking bench for inv_mix_col_seq.
module tb_inv_mix_col_seq;

`ifdef INV_MIX_COL_DUAL_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 5;
`endif
    localparam int NR = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    always #5 clk = ~clk;

    inv_mix_col_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply for the forward reference
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            r[119-32*c -: 8] = gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3 ^ a0;
            r[111-32*c -: 8] = gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03) ^ a0 ^ a1;
            r[103-32*c -: 8] = gf_mul(a3, 8'h02) ^ gf_mul(a0, 8'h03) ^ a1 ^ a2;
        end
        return r;
    endfunction

    task automatic run_txn(input logic [127:0] st, input logic byp,
                           output int lat, output logic [127:0] got, output logic saw_busy);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid  = 1'b1;
        in_state  = st;
        in_bypass = byp;
        saw_busy  = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (busy) saw_busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        got = out_state;
    endtask

    typedef struct {
        logic [127:0] st;
        logic         byp;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t         vecs[4];
    int           lat;
    logic [127:0] got;
    logic         saw_busy;
    logic [128:0] q[$];
    int           rx;

    initial begin
        vecs[0] = '{128'h8e4da1bc_4d7ebdf8_d5d5d7d6_01010101, 1'b0,
                    128'hdb135345_2d26314c_d4d4d4d5_01010101, LAT};
        vecs[1] = '{128'h9fdc589d_c6c6c6c6_ffffffff_00000000, 1'b0,
                    128'hf20a225c_c6c6c6c6_ffffffff_00000000, LAT};
        vecs[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                    128'h00112233_44556677_8899aabb_ccddeeff, 1};
        vecs[3] = '{128'h9fdc589d_c6c6c6c6_ffffffff_00000000, 1'b1,
                    128'h9fdc589d_c6c6c6c6_ffffffff_00000000, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_state", out_state, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Table-driven known answers, full-speed downstream
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].st, vecs[i].byp, lat, got, saw_busy);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
            check($sformatf("vec%0d_state", i), got, vecs[i].exp);
            check($sformatf("vec%0d_busy_seen", i), 128'(saw_busy), 128'(!vecs[i].byp));
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", i), 128'(out_valid), 128'(0));
            check($sformatf("vec%0d_ready_rise", i), 128'(in_ready), 128'(1));
        end

        // Backpressure: hold DONE for 10 cycles
        out_ready = 1'b0;
        run_txn(vecs[0].st, 1'b0, lat, got, saw_busy);
        check("bp_latency", 128'(lat), 128'(LAT));
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_valid_%0d", k), 128'(out_valid), 128'(1));
            check($sformatf("bp_state_%0d", k), out_state, vecs[0].exp);
            check($sformatf("bp_in_ready_%0d", k), 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 128'(out_valid), 128'(0));
        check("bp_release_ready", 128'(in_ready), 128'(1));

        // Reset while column 2 is in flight
        in_valid  = 1'b1;
        in_state  = vecs[1].st;
        in_bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat ((LAT - 1) / 2) @(negedge clk);
        check("mid_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_state", out_state, 128'h0);
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_back", 128'(in_ready), 128'(1));
        run_txn(vecs[0].st, 1'b0, lat, got, saw_busy);
        check("after_rst_latency", 128'(lat), 128'(LAT));
        check("after_rst_state", got, vecs[0].exp);
        @(negedge clk);

        // Random back-to-back traffic against a forward-MixColumns reference
        rx = 0;
        fork
            begin
                int w;
                for (int i = 0; i < NR; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    in_state  = {$urandom, $urandom, $urandom, $urandom};
                    in_bypass = ($urandom_range(0, 3) == 0);
                    in_valid  = 1'b1;
                    w = 0;
                    while (!in_ready && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (in_ready) begin
                        q.push_back({in_bypass, in_state});
                    end else begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rnd_accept_timeout: txn %0d never accepted", i);
                    end
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            begin
                logic [128:0] e;
                int           cyc;
                cyc = 0;
                while (rx < NR && cyc < 50000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 1) == 1);
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL rnd_dup: got %h expected no output", out_state);
                        end else begin
                            e = q.pop_front();
                            rx++;
                            if (e[128]) check("rnd_bypass", out_state, e[127:0]);
                            else        check("rnd_mix", mix_cols(out_state), e[127:0]);
                        end
                    end
                end
            end
        join
        check("rnd_count", 128'(rx), 128'(NR));
        check("rnd_pending", 128'(q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
